// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 32-entry register file: clears every entry
// after reset or on command, then round-robins the single write port between
// the writeback (wb) and load-return (ld) requesters.
module regfile_write_arbiter #(
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned DATA_W = 24,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_start,
   output logic              init_busy,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_index,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   input  logic              ld_valid,
   input  logic [IDX_W-1:0]  ld_index,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              rf_write_enable,
   output logic [IDX_W-1:0]  rf_write_index,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [CNT_W-1:0]  conflict_count
);

   localparam int unsigned LAST_IDX = (1 << IDX_W) - 1;
   localparam logic GRANT_WB = 1'b0;
   localparam logic GRANT_LD = 1'b1;

   typedef enum logic {ST_INIT, ST_ARB} state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_cnt;
   logic                r_init_busy;
   logic                r_we;
   logic [IDX_W-1:0]    r_idx;
   logic [DATA_W-1:0]   r_data;
   logic                r_last_grant;
   logic [CNT_W-1:0]    r_conflict;

   logic                w_arb_go;
   logic                w_both;
   logic                w_wb_grant;
   logic                w_ld_grant;

   // Grant decision: a tie goes to whichever requester was not served last
   always_comb begin
      w_arb_go   = (r_state == ST_ARB) && !init_start;
      w_both     = wb_valid && ld_valid;
      w_wb_grant = w_arb_go && wb_valid && (!ld_valid || (r_last_grant == GRANT_LD));
      w_ld_grant = w_arb_go && ld_valid && (!wb_valid || (r_last_grant == GRANT_WB));
   end

   assign wb_ready        = w_wb_grant;
   assign ld_ready        = w_ld_grant;
   assign init_busy       = r_init_busy;
   assign rf_write_enable = r_we;
   assign rf_write_index  = r_idx;
   assign rf_write_data   = r_data;
   assign conflict_count  = r_conflict;

   // Clear sequencer, arbitration state, registered write port and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_INIT;
         r_cnt        <= '0;
         r_init_busy  <= 1'b1;
         r_we         <= 1'b0;
         r_idx        <= '0;
         r_data       <= '0;
         r_last_grant <= GRANT_LD;
         r_conflict   <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_we   <= 1'b1;
               r_idx  <= r_cnt;
               r_data <= '0;
               if (r_cnt == IDX_W'(LAST_IDX)) begin
                  r_state     <= ST_ARB;
                  r_init_busy <= 1'b0;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + IDX_W'(1);
               end
            end
            ST_ARB: begin
               if (init_start) begin
                  r_state     <= ST_INIT;
                  r_init_busy <= 1'b1;
                  r_cnt       <= '0;
                  r_we        <= 1'b0;
               end else begin
                  if (w_wb_grant) begin
                     r_we   <= 1'b1;
                     r_idx  <= wb_index;
                     r_data <= wb_data;
                  end else if (w_ld_grant) begin
                     r_we   <= 1'b1;
                     r_idx  <= ld_index;
                     r_data <= ld_data;
                  end else begin
                     r_we <= 1'b0;
                  end
                  if (w_both) begin
                     r_last_grant <= w_wb_grant ? GRANT_WB : GRANT_LD;
                     if (r_conflict != {CNT_W{1'b1}}) begin
                        r_conflict <= r_conflict + CNT_W'(1);
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
